sdp_ram_be_clr: RTL
===================

# sdp_ram_be_clr

Single-clock simple-dual-port RAM with one write port (A) and one read port (B). It is the parametrised successor of the team's block dual-port RAM, adding generic data width, per-byte write enables, a selectable read-during-write collision policy, and an optional output pipeline register. It also adds a hardware clear sequencer that zeroes the array after reset or on request. It sits between pixel/sprite producers and the display/engine readers wherever a single clock domain suffices.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 10, address width; DEPTH = 2**ADDR_WIDTH words
- OUT_REG, 0, 1 adds an output register stage (read latency 2), 0 gives latency 1
- WR_FWD, 1, same-address collision policy: 1 = new data forwarded, 0 = old data returned

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wea  in  1  port-A write enable
- addra  in  ADDR_WIDTH  write address
- dina  in  DATA_WIDTH  write data
- bea  in  DATA_WIDTH/8  byte enables; bit i gates dina[8i+7:8i]
- reb  in  1  port-B read enable
- addrb  in  ADDR_WIDTH  read address
- doutb  out  DATA_WIDTH  read data
- doutb_valid  out  1  one-cycle pulse marking new doutb
- clr_req  in  1  request a full-array clear
- busy  out  1  clear sequencer active; ports A/B are blocked

## Operation
- FSM states: CLR and READY. rst forces CLR with clear counter = 0.
- CLR: each cycle writes 0 to mem[cnt] and increments cnt. When cnt == DEPTH-1 the FSM writes that last word and moves to READY. busy = 1 in CLR.
- READY: busy = 0. A clr_req sampled high moves the FSM to CLR with cnt = 0.
- clr_req in CLR is ignored; the clear is neither restarted nor extended.
- Write (READY only): for each byte i with wea & bea[i], mem[addra] byte i <= dina byte i. wea with bea = 0 is a no-op.
- Read (READY only): reb loads mem[addrb] into the read pipeline.
- While busy, wea and reb are ignored: no write, no doutb_valid.
- doutb holds its last value when no read completes.
- Collision (wea & reb & addra == addrb, same cycle):
  - WR_FWD=1: returned word is enabled bytes from dina, other bytes from old memory contents.
  - WR_FWD=0: returned word is the entire old word.
  - The write is performed in both cases.
- Clear writes never forward.
- Reset:
  - Memory contents are not reset directly; they are zeroed by the clear that follows.
  - rst mid-clear restarts the clear at address 0.
  - rst mid-read drops in-flight reads: doutb_valid = 0 and the pipeline register clears.

## Timing
- Reset values: doutb = 0, doutb_valid = 0, busy = 1, FSM = CLR, cnt = 0.
- Clear duration:
  - rst high at edge k. With rst low from edge k+1, edges k+1..k+DEPTH write addresses 0..DEPTH-1.
  - busy is low after edge k+DEPTH; the first accepted access is at edge k+DEPTH+1.
- A clr_req sampled at edge j gives busy = 1 after edge j. The clear occupies edges j+1..j+DEPTH; busy = 0 after edge j+DEPTH.
- Read latency is measured from the edge that samples reb:
  - OUT_REG=0: doutb and doutb_valid update at that edge.
  - OUT_REG=1: they update one edge later.
- Full throughput: one read and one write per cycle, back-to-back, any addresses.
- A write at edge n is visible to a non-colliding read sampled at edge n+1.

## Test plan
- Post-reset clear, ADDR_WIDTH=4:
  - Stimulus: pulse rst, then read all 16 words.
  - Required: busy high for exactly 16 cycles after rst falls; every word reads 0.
- Byte enables, DATA_WIDTH=32:
  - Stimulus: write 0xAABBCCDD to addr 5 with bea=1111, then 0x11223344 with bea=0101, then read addr 5.
  - Required: 0xAA22CC44.
- Collision, WR_FWD=1:
  - Stimulus: addr 3 holds 0x00000000; in the same cycle write 0xFFFFFFFF with bea=0011 and read addr 3.
  - Required: 0x0000FFFF.
  - Repeat with WR_FWD=0: required 0x00000000, and a read on the next cycle returns 0x0000FFFF.
- Latency, OUT_REG=1:
  - Stimulus: reb high for 4 consecutive cycles on addresses 0..3, preloaded 10, 11, 12, 13.
  - Required: doutb_valid high for 4 cycles starting 2 edges after the first reb; data 10, 11, 12, 13 in order.
- clr_req handling:
  - Stimulus: fill memory with nonzero data; assert clr_req; during busy issue wea to addr 7 and reb, and re-pulse clr_req.
  - Required: no doutb_valid; busy lasts exactly DEPTH cycles; addr 7 reads 0 afterwards.
- Reset mid-clear:
  - Stimulus: assert rst at clear cycle 9 of 16.
  - Required: after rst falls, busy stays high a further full 16 cycles; all words read 0.

Source files
------------

// File: rtl/sdp_ram_be_clr_if.sv
// Port bundle for sdp_ram_be_clr: write port A, read port B, and clear control/status.
// The master drives requests; the slave is the RAM.
interface sdp_ram_be_clr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                      wea;
  logic [ADDR_WIDTH-1:0]     addra;
  logic [DATA_WIDTH-1:0]     dina;
  logic [DATA_WIDTH/8-1:0]   bea;
  logic                      reb;
  logic [ADDR_WIDTH-1:0]     addrb;
  logic [DATA_WIDTH-1:0]     doutb;
  logic                      doutb_valid;
  logic                      clr_req;
  logic                      busy;

  modport master (
    output wea, addra, dina, bea, reb, addrb, clr_req,
    input  doutb, doutb_valid, busy
  );

  modport slave (
    input  wea, addra, dina, bea, reb, addrb, clr_req,
    output doutb, doutb_valid, busy
  );
endinterface

// File: rtl/sdp_ram_be_clr.sv
// Single-clock SDP RAM, byte enables, clear sequencer; read latency 1 (OUT_REG=0) or 2.
// No backpressure: while busy is high both ports are ignored.
module sdp_ram_be_clr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_REG    = 0,
  parameter int WR_FWD     = 1
) (
  input logic               clk,
  input logic               rst,
  sdp_ram_be_clr_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {CLR, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic                    vld_q;
  logic                    wr_fire;
  logic                    rd_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (&cnt_q) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        if (bus.clr_req) begin
          state_d = CLR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLR;
    endcase
  end

  assign wr_fire  = (state_q == READY) && bus.wea;
  assign rd_fire  = (state_q == READY) && bus.reb;
  assign bus.busy = (state_q == CLR);

  // Forwarded word merges the enabled new bytes over the old contents.
  always_comb begin
    rd_word = mem[bus.addrb];
    if (WR_FWD != 0 && wr_fire && bus.addra == bus.addrb) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.bea[i]) rd_word[8*i +: 8] = bus.dina[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLR) begin
        mem[cnt_q] <= '0;
      end else if (wr_fire) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.bea[i]) mem[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  s1_vld_q;
      logic [DATA_WIDTH-1:0] s1_dat_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_vld_q <= 1'b0;
          s1_dat_q <= '0;
          vld_q    <= 1'b0;
          dout_q   <= '0;
        end else begin
          s1_vld_q <= rd_fire;
          if (rd_fire) s1_dat_q <= rd_word;
          vld_q <= s1_vld_q;
          if (s1_vld_q) dout_q <= s1_dat_q;
        end
      end
    end else begin : g_noreg
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q  <= 1'b0;
          dout_q <= '0;
        end else begin
          vld_q <= rd_fire;
          if (rd_fire) dout_q <= rd_word;
        end
      end
    end
  endgenerate

  assign bus.doutb       = dout_q;
  assign bus.doutb_valid = vld_q;
endmodule
